apb_mul_ctrl: RTL

- Parametrised APB slave that fronts a multi-cycle multiplier core.
- Holds operand registers and a control register with a self-clearing start.
- Tracks the operation with a BUSY/IDLE state machine, a cycle counter and a timeout; latches the multi-word result.
- Exposes sticky done/timeout status and an optional interrupt.
- Sits between the APB interconnect and the multiplier core; replaces the single-register-per-operand interface.

---
 rtl/apb_mul_pkg.sv | 25 ++
 rtl/apb_mul_seq.sv | 98 +++++++++
 rtl/apb_mul_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/apb_mul_pkg.sv
// apb_mul_ctrl shared definitions.
// Register offsets, bit positions and sequencer states.
package apb_mul_pkg;

  localparam logic [4:0] OFF_OP_A   = 5'h00;
  localparam logic [4:0] OFF_OP_B   = 5'h04;
  localparam logic [4:0] OFF_CTRL   = 5'h08;
  localparam logic [4:0] OFF_STATUS = 5'h0C;
  localparam logic [4:0] OFF_RES_LO = 5'h10;
  localparam logic [4:0] OFF_RES_HI = 5'h14;
  localparam logic [4:0] OFF_CYCLES = 5'h18;

  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_TIMEOUT = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/apb_mul_seq.sv
// apb_mul_ctrl operation sequencer.
// Start pulse, cycle counting, timeout and result capture.
module apb_mul_seq
  import apb_mul_pkg::*;
#(
  parameter int OUT_W          = 32,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_WIDTH      = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 mul_valid_i,
  input  logic [OUT_W-1:0]     mul_result_i,
  output logic                 busy_o,
  output logic                 mul_start_o,
  output logic                 done_set_o,
  output logic                 tout_set_o,
  output logic [OUT_W-1:0]     result_o,
  output logic [CNT_WIDTH-1:0] cycles_o
);

  localparam logic [CNT_WIDTH-1:0] TO_LAST =
    CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE =
    CNT_WIDTH'(1);

  if (TIMEOUT_CYCLES < 2) begin : g_to_chk
    $error("apb_mul_seq: TIMEOUT_CYCLES must be >= 2");
  end

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] cyc_q, cyc_d;
  logic [OUT_W-1:0]     res_q, res_d;
  logic                 start_q, start_d;
  logic                 done_set, tout_set;

  // Next-state: launch on start, finish on valid or timeout
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cyc_d    = cyc_q;
    res_d    = res_q;
    start_d  = 1'b0;
    done_set = 1'b0;
    tout_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = BUSY;
          start_d = 1'b1;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (mul_valid_i) begin
          res_d    = mul_result_i;
          cyc_d    = cnt_q;
          done_set = 1'b1;
          state_d  = IDLE;
        end else if (cnt_q == TO_LAST) begin
          cyc_d    = cnt_q;
          tout_set = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state and captured values
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cyc_q   <= '0;
      res_q   <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      res_q   <= res_d;
      start_q <= start_d;
    end
  end

  assign busy_o      = (state_q == BUSY);
  assign mul_start_o = start_q;
  assign done_set_o  = done_set;
  assign tout_set_o  = tout_set;
  assign result_o    = res_q;
  assign cycles_o    = cyc_q;

endmodule

// File: rtl/apb_mul_ctrl.sv
// apb_mul_ctrl: APB slave fronting a multi-cycle multiplier.
// Operand/control registers, sticky status and interrupt.
module apb_mul_ctrl
  import apb_mul_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int OP_A_WIDTH     = 16,
  parameter int OP_B_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_WIDTH      = $clog2(TIMEOUT_CYCLES) + 1
) (
  input  logic                            PCLK,
  input  logic                            PRESET,
  input  logic [ADDR_WIDTH-1:0]           PADDR,
  input  logic                            PSEL,
  input  logic                            PENABLE,
  input  logic                            PWRITE,
  input  logic [DATA_WIDTH-1:0]           PWDATA,
  output logic [DATA_WIDTH-1:0]           PRDATA,
  output logic                            PREADY,
  output logic                            PSLVERR,
  output logic [OP_A_WIDTH-1:0]           mul_a_o,
  output logic [OP_B_WIDTH-1:0]           mul_b_o,
  output logic                            mul_start_o,
  input  logic [OP_A_WIDTH+OP_B_WIDTH-1:0] mul_result_i,
  input  logic                            mul_valid_i,
  output logic                            irq_o
);

  localparam int OUT_W = OP_A_WIDTH + OP_B_WIDTH;

  if (DATA_WIDTH != 32) begin : g_dw_chk
    $error("apb_mul_ctrl: DATA_WIDTH must be 32");
  end
  if (OP_A_WIDTH < 1 || OP_A_WIDTH > 32) begin : g_a_chk
    $error("apb_mul_ctrl: OP_A_WIDTH must be 1..32");
  end
  if (OP_B_WIDTH < 1 || OP_B_WIDTH > 32) begin : g_b_chk
    $error("apb_mul_ctrl: OP_B_WIDTH must be 1..32");
  end

  logic [OP_A_WIDTH-1:0] op_a_q, op_a_d;
  logic [OP_B_WIDTH-1:0] op_b_q, op_b_d;
  logic                  irq_en_q, irq_en_d;
  logic                  done_q, done_d;
  logic                  tout_q, tout_d;
  logic                  irq_q, irq_d;

  logic                 busy, done_set, tout_set;
  logic [OUT_W-1:0]     result;
  logic [CNT_WIDTH-1:0] cycles;
  logic [63:0]          res_ext;

  logic       access, aligned, hit, ro_sel, busy_lock;
  logic       err, wr_ok, rd_ok, start_req;
  logic [4:0] off;
  logic       sel_op_a, sel_op_b, sel_ctrl, sel_status;
  logic       sel_res_lo, sel_res_hi, sel_cycles;
  logic [31:0] rdata;
  logic        unused_ok;

  // Address decode and transfer qualification
  always_comb begin
    access     = PSEL & PENABLE;
    off        = PADDR[4:0];
    aligned    = (off[1:0] == 2'b00);
    sel_op_a   = aligned && (off == OFF_OP_A);
    sel_op_b   = aligned && (off == OFF_OP_B);
    sel_ctrl   = aligned && (off == OFF_CTRL);
    sel_status = aligned && (off == OFF_STATUS);
    sel_res_lo = aligned && (off == OFF_RES_LO);
    sel_res_hi = aligned && (off == OFF_RES_HI);
    sel_cycles = aligned && (off == OFF_CYCLES);
    hit = sel_op_a | sel_op_b | sel_ctrl | sel_status |
          sel_res_lo | sel_res_hi | sel_cycles;
    ro_sel    = sel_res_lo | sel_res_hi | sel_cycles;
    busy_lock = busy & (sel_op_a | sel_op_b | sel_ctrl);
    err   = access & (~hit | (PWRITE & (ro_sel | busy_lock)));
    wr_ok = access & PWRITE & ~err;
    rd_ok = access & ~PWRITE & ~err;
    start_req = wr_ok & sel_ctrl & PWDATA[CTRL_START];
  end

  // Register updates; hardware sets beat W1C and start clears
  always_comb begin
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    irq_en_d = irq_en_q;
    done_d   = done_q;
    tout_d   = tout_q;
    if (wr_ok & sel_op_a) op_a_d = PWDATA[OP_A_WIDTH-1:0];
    if (wr_ok & sel_op_b) op_b_d = PWDATA[OP_B_WIDTH-1:0];
    if (wr_ok & sel_ctrl) irq_en_d = PWDATA[CTRL_IRQ_EN];
    if (wr_ok & sel_status & PWDATA[ST_DONE])    done_d = 1'b0;
    if (wr_ok & sel_status & PWDATA[ST_TIMEOUT]) tout_d = 1'b0;
    if (start_req) begin
      done_d = 1'b0;
      tout_d = 1'b0;
    end
    if (done_set) done_d = 1'b1;
    if (tout_set) tout_d = 1'b1;
    irq_d = irq_en_q & (done_q | tout_q);
  end

  // Register file and interrupt flop
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      op_a_q   <= '0;
      op_b_q   <= '0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      tout_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
      tout_q   <= tout_d;
      irq_q    <= irq_d;
    end
  end

  assign res_ext = 64'(result);

  // Read mux; erroring or idle bus returns zero
  always_comb begin
    rdata = '0;
    if (rd_ok) begin
      unique case (1'b1)
        sel_op_a:   rdata = 32'(op_a_q);
        sel_op_b:   rdata = 32'(op_b_q);
        sel_ctrl:   rdata = {30'b0, irq_en_q, 1'b0};
        sel_status: rdata = {29'b0, tout_q, done_q, busy};
        sel_res_lo: rdata = res_ext[31:0];
        sel_res_hi: rdata = res_ext[63:32];
        sel_cycles: rdata = 32'(cycles);
        default:    rdata = '0;
      endcase
    end
  end

  apb_mul_seq #(
    .OUT_W          (OUT_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_WIDTH      (CNT_WIDTH)
  ) u_seq (
    .clk          (PCLK),
    .rst          (PRESET),
    .start_i      (start_req),
    .mul_valid_i  (mul_valid_i),
    .mul_result_i (mul_result_i),
    .busy_o       (busy),
    .mul_start_o  (mul_start_o),
    .done_set_o   (done_set),
    .tout_set_o   (tout_set),
    .result_o     (result),
    .cycles_o     (cycles)
  );

  assign PREADY  = access & ~PRESET;
  assign PSLVERR = err & ~PRESET;
  assign PRDATA  = PRESET ? '0 : DATA_WIDTH'(rdata);
  assign mul_a_o = op_a_q;
  assign mul_b_o = op_b_q;
  assign irq_o   = irq_q;

  assign unused_ok = ^{PADDR, PWDATA};

endmodule
